// File: rtl/mcyc_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: states, exception causes,
// instruction classes, opcode/funct values and the datapath control codes.
package mcyc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_EXCEPT = 3'd6
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    typedef enum logic [3:0] {
        CL_RALU, CL_IALU, CL_LOAD, CL_STORE, CL_BRANCH,
        CL_JUMP, CL_JAL, CL_JR, CL_ILLEGAL
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2a;
    localparam logic [5:0] F_SLTU = 6'h2b;

    // ALUOp_BNE makes the ALU raise Zero on inequality, so Zero is always "take branch".
    localparam logic [4:0] ALUOp_NOP  = 5'd0;
    localparam logic [4:0] ALUOp_ADD  = 5'd1;
    localparam logic [4:0] ALUOp_SUB  = 5'd2;
    localparam logic [4:0] ALUOp_AND  = 5'd3;
    localparam logic [4:0] ALUOp_OR   = 5'd4;
    localparam logic [4:0] ALUOp_XOR  = 5'd5;
    localparam logic [4:0] ALUOp_NOR  = 5'd6;
    localparam logic [4:0] ALUOp_SLT  = 5'd7;
    localparam logic [4:0] ALUOp_SLTU = 5'd8;
    localparam logic [4:0] ALUOp_SLL  = 5'd9;
    localparam logic [4:0] ALUOp_SRL  = 5'd10;
    localparam logic [4:0] ALUOp_SRA  = 5'd11;
    localparam logic [4:0] ALUOp_LUI  = 5'd12;
    localparam logic [4:0] ALUOp_BNE  = 5'd13;

    localparam logic [2:0] NPC_PLUS4  = 3'd0;
    localparam logic [2:0] NPC_BRANCH = 3'd1;
    localparam logic [2:0] NPC_JUMP   = 3'd2;
    localparam logic [2:0] NPC_JR     = 3'd3;
    localparam logic [2:0] NPC_EXCEPT = 3'd4;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    localparam logic [1:0] GPRSel_RD  = 2'd0;
    localparam logic [1:0] GPRSel_RT  = 2'd1;
    localparam logic [1:0] GPRSel_31  = 2'd2;

    localparam logic [2:0] WDSel_FromALU = 3'd0;
    localparam logic [2:0] WDSel_FromMEM = 3'd1;
    localparam logic [2:0] WDSel_FromPC  = 3'd2;

    function automatic iclass_t classify(input logic [5:0] op, input logic [5:0] fn);
        iclass_t c;
        c = CL_ILLEGAL;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    F_JR: c = CL_JR;
                    F_SLL, F_SRL, F_SRA, F_ADD, F_ADDU, F_SUB, F_SUBU,
                    F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: c = CL_RALU;
                    default: c = CL_ILLEGAL;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: c = CL_IALU;
            OP_LW:          c = CL_LOAD;
            OP_SW:          c = CL_STORE;
            OP_BEQ, OP_BNE: c = CL_BRANCH;
            OP_J:           c = CL_JUMP;
            OP_JAL:         c = CL_JAL;
            default:        c = CL_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mcyc_decode.sv
// Combinational instruction classifier: opcode/funct to class, ALU operation,
// A-operand select and immediate extension mode. No state, zero latency.
module mcyc_decode
    import mcyc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    iclass,
    output logic [4:0] aluop,
    output logic       asel,
    output logic [1:0] extop
);

    always_comb begin
        iclass = classify(opcode, funct);
        aluop  = ALUOp_NOP;
        asel   = 1'b0;
        extop  = EXT_ZERO;
        case (iclass)
            CL_RALU: begin
                case (funct)
                    F_ADD, F_ADDU: aluop = ALUOp_ADD;
                    F_SUB, F_SUBU: aluop = ALUOp_SUB;
                    F_AND:         aluop = ALUOp_AND;
                    F_OR:          aluop = ALUOp_OR;
                    F_XOR:         aluop = ALUOp_XOR;
                    F_NOR:         aluop = ALUOp_NOR;
                    F_SLT:         aluop = ALUOp_SLT;
                    F_SLTU:        aluop = ALUOp_SLTU;
                    F_SLL: begin aluop = ALUOp_SLL; asel = 1'b1; end
                    F_SRL: begin aluop = ALUOp_SRL; asel = 1'b1; end
                    F_SRA: begin aluop = ALUOp_SRA; asel = 1'b1; end
                    default:       aluop = ALUOp_NOP;
                endcase
            end
            CL_IALU: begin
                case (opcode)
                    OP_ADDI, OP_ADDIU: begin aluop = ALUOp_ADD;  extop = EXT_SIGN; end
                    OP_SLTI:           begin aluop = ALUOp_SLT;  extop = EXT_SIGN; end
                    OP_SLTIU:          begin aluop = ALUOp_SLTU; extop = EXT_SIGN; end
                    OP_ANDI:           aluop = ALUOp_AND;
                    OP_ORI:            aluop = ALUOp_OR;
                    OP_XORI:           aluop = ALUOp_XOR;
                    OP_LUI:            begin aluop = ALUOp_LUI;  extop = EXT_LUI;  end
                    default:           aluop = ALUOp_NOP;
                endcase
            end
            CL_LOAD, CL_STORE: begin
                aluop = ALUOp_ADD;
                extop = EXT_SIGN;
            end
            CL_BRANCH: begin
                aluop = (opcode == OP_BNE) ? ALUOp_BNE : ALUOp_SUB;
                extop = EXT_SIGN;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mcyc_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB over one ALU and one memory port.
// Latency 3-5 cycles at zero-wait memory; stalls on mem_ready and traps after MEM_TIMEOUT waits.
module mcyc_ctrl
    import mcyc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = $clog2(MEM_TIMEOUT)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       IRWr,
    output logic       PCWr,
    output logic       RFWr,
    output logic       DMWr,
    output logic [4:0] ALUOp,
    output logic [2:0] NPCOp,
    output logic [1:0] EXTOp,
    output logic       ASel,
    output logic       BSel,
    output logic [1:0] GPRSel,
    output logic [2:0] WDSel,
    output logic       instr_done,
    output logic       exc,
    output logic [1:0] exc_cause,
    output logic [2:0] state
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           cur_state, next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             cnt_inc;
    logic [5:0]       lat_opcode, lat_funct;
    logic [1:0]       cause_q, cause_nxt;
    iclass_t          live_class;
    iclass_t          lat_class;
    logic [4:0]       lat_aluop;
    logic             lat_asel;
    logic [1:0]       lat_extop;
    logic             mem_tmo;

    // DECODE judges legality on the live IR; everything after uses the latched copy.
    assign live_class = classify(opcode, funct);
    assign mem_tmo    = (wait_cnt == TMO_LAST);
    assign state      = cur_state;
    assign exc_cause  = cause_q;

    mcyc_decode u_decode (
        .opcode (lat_opcode),
        .funct  (lat_funct),
        .iclass (lat_class),
        .aluop  (lat_aluop),
        .asel   (lat_asel),
        .extop  (lat_extop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state  <= ST_IDLE;
            wait_cnt   <= '0;
            lat_opcode <= '0;
            lat_funct  <= '0;
            cause_q    <= CAUSE_NONE;
        end else begin
            cur_state <= next_state;
            if (next_state != cur_state) begin
                wait_cnt <= '0;
            end else if (cnt_inc) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (cur_state == ST_DECODE) begin
                lat_opcode <= opcode;
                lat_funct  <= funct;
            end
            if (next_state == ST_EXCEPT) begin
                cause_q <= cause_nxt;
            end
        end
    end

    always_comb begin
        next_state = cur_state;
        cnt_inc    = 1'b0;
        cause_nxt  = CAUSE_NONE;
        mem_req    = 1'b0;
        IorD       = 1'b0;
        IRWr       = 1'b0;
        PCWr       = 1'b0;
        RFWr       = 1'b0;
        DMWr       = 1'b0;
        ALUOp      = ALUOp_NOP;
        NPCOp      = NPC_PLUS4;
        EXTOp      = EXT_ZERO;
        ASel       = 1'b0;
        BSel       = 1'b0;
        GPRSel     = GPRSel_RD;
        WDSel      = WDSel_FromALU;
        instr_done = 1'b0;
        exc        = 1'b0;

        case (cur_state)
            ST_IDLE: next_state = ST_FETCH;

            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IRWr       = 1'b1;
                    next_state = ST_DECODE;
                end else if (mem_tmo) begin
                    next_state = ST_EXCEPT;
                    cause_nxt  = CAUSE_TIMEOUT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            ST_DECODE: begin
                if (live_class == CL_ILLEGAL) begin
                    next_state = ST_EXCEPT;
                    cause_nxt  = CAUSE_ILLEGAL;
                end else begin
                    next_state = ST_EXEC;
                end
            end

            ST_EXEC: begin
                ALUOp = lat_aluop;
                ASel  = lat_asel;
                EXTOp = lat_extop;
                BSel  = (lat_class == CL_IALU) || (lat_class == CL_LOAD) ||
                        (lat_class == CL_STORE);
                case (lat_class)
                    CL_RALU, CL_IALU:   next_state = ST_WB;
                    CL_LOAD, CL_STORE:  next_state = ST_MEM;
                    CL_BRANCH: begin
                        NPCOp      = Zero ? NPC_BRANCH : NPC_PLUS4;
                        PCWr       = 1'b1;
                        instr_done = 1'b1;
                        next_state = ST_FETCH;
                    end
                    CL_JUMP, CL_JAL: begin
                        NPCOp      = NPC_JUMP;
                        PCWr       = 1'b1;
                        instr_done = 1'b1;
                        next_state = ST_FETCH;
                        if (lat_class == CL_JAL) begin
                            RFWr   = 1'b1;
                            GPRSel = GPRSel_31;
                            WDSel  = WDSel_FromPC;
                        end
                    end
                    CL_JR: begin
                        NPCOp      = NPC_JR;
                        PCWr       = 1'b1;
                        instr_done = 1'b1;
                        next_state = ST_FETCH;
                    end
                    default: begin
                        next_state = ST_EXCEPT;
                        cause_nxt  = CAUSE_ILLEGAL;
                    end
                endcase
            end

            ST_MEM: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                DMWr    = (lat_class == CL_STORE);
                if (mem_ready) begin
                    if (lat_class == CL_STORE) begin
                        PCWr       = 1'b1;
                        instr_done = 1'b1;
                        next_state = ST_FETCH;
                    end else begin
                        next_state = ST_WB;
                    end
                end else if (mem_tmo) begin
                    next_state = ST_EXCEPT;
                    cause_nxt  = CAUSE_TIMEOUT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            ST_WB: begin
                RFWr       = 1'b1;
                PCWr       = 1'b1;
                instr_done = 1'b1;
                GPRSel     = (lat_class == CL_RALU) ? GPRSel_RD : GPRSel_RT;
                WDSel      = (lat_class == CL_LOAD) ? WDSel_FromMEM : WDSel_FromALU;
                next_state = ST_FETCH;
            end

            ST_EXCEPT: begin
                exc        = 1'b1;
                NPCOp      = NPC_EXCEPT;
                PCWr       = 1'b1;
                next_state = ST_FETCH;
            end

            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mcyc_ctrl.sv
// Directed bench for mcyc_ctrl: a table of instructions with hand-computed expectations,
// plus sequences for exception-cause hold and asynchronous reset during a store.
module tb_mcyc_ctrl;

    logic       clk, rst_n;
    logic [5:0] opcode, funct;
    logic       Zero, mem_ready;
    logic       mem_req, IorD, IRWr, PCWr, RFWr, DMWr;
    logic [4:0] ALUOp;
    logic [2:0] NPCOp;
    logic [1:0] EXTOp;
    logic       ASel, BSel;
    logic [1:0] GPRSel;
    logic [2:0] WDSel;
    logic       instr_done, exc;
    logic [1:0] exc_cause;
    logic [2:0] state;
    logic [29:0] all_outs;

    mcyc_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .Zero(Zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD), .IRWr(IRWr),
        .PCWr(PCWr), .RFWr(RFWr), .DMWr(DMWr), .ALUOp(ALUOp), .NPCOp(NPCOp),
        .EXTOp(EXTOp), .ASel(ASel), .BSel(BSel), .GPRSel(GPRSel), .WDSel(WDSel),
        .instr_done(instr_done), .exc(exc), .exc_cause(exc_cause), .state(state)
    );

    assign all_outs = {mem_req, IorD, IRWr, PCWr, RFWr, DMWr, ALUOp, NPCOp, EXTOp,
                       ASel, BSel, GPRSel, WDSel, instr_done, exc, exc_cause, state};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Observations gathered over one instruction.
    int c_cyc, c_alu, c_asel, c_bsel, c_ext, c_npc, c_pcwr, c_rfst, c_gpr, c_wd;
    int c_iord, c_dmwr, c_dmwr_exc, c_done, c_exc, c_cause;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int fdly, mdly, cyc;
        int alu, asel, bsel, ext, npc;
        int rfst, gpr, wd;
        int iord, dmwr, exc, cause;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Entry and exit: one time unit after a falling edge, DUT in FETCH.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fdly, input int mdly);
        int wc;
        logic [2:0] prev;
        logic fin;
        opcode = op; funct = fn; Zero = z;
        c_cyc = 0; c_alu = 0; c_asel = 0; c_bsel = 0; c_ext = 0; c_npc = 0; c_pcwr = 0;
        c_rfst = 0; c_gpr = 0; c_wd = 0; c_iord = 0; c_dmwr = 0; c_dmwr_exc = 0;
        c_done = 0; c_exc = 0; c_cause = 0;
        wc = 0; prev = 3'd7; fin = 1'b0;
        for (int c = 1; c <= 64 && !fin; c++) begin
            if (state != prev) wc = 0;
            prev = state;
            mem_ready = ((state == 3'd1) && (wc >= fdly)) || ((state == 3'd4) && (wc >= mdly));
            #1;
            if (state == 3'd3) begin
                c_alu = int'(ALUOp); c_asel = int'(ASel); c_bsel = int'(BSel); c_ext = int'(EXTOp);
            end
            if (PCWr) begin c_pcwr++; c_npc = int'(NPCOp); end
            if (RFWr) begin c_rfst = int'(state); c_gpr = int'(GPRSel); c_wd = int'(WDSel); end
            if (IorD) c_iord++;
            if (DMWr) c_dmwr++;
            if (exc && DMWr) c_dmwr_exc++;
            if (instr_done) c_done++;
            if (exc) c_exc++;
            if (instr_done || exc) begin
                c_cyc = c; c_cause = int'(exc_cause); fin = 1'b1;
            end
            wc++;
            @(negedge clk); #1;
        end
        if (!fin) begin
            total++; bad++;
            $display("FAIL retire_bound: op=%h got no retire within 64 cycles expected retire", op);
        end
    endtask

    initial begin
        logic fin;
        // op, fn, Zero, fetch delay, mem delay, cycles, ALUOp, ASel, BSel, EXTOp, NPCOp,
        // state at RFWr, GPRSel, WDSel, IorD cycles, DMWr cycles, exc, cause
        vt[0]  = '{6'h00, 6'h21, 1'b0, 0,   0,   4,  1, 0, 0, 0, 0, 5, 0, 0, 0,  0,  0, 0}; // addu
        vt[1]  = '{6'h23, 6'h00, 1'b0, 3,   3,   11, 1, 0, 1, 1, 0, 5, 1, 1, 4,  0,  0, 0}; // lw, slow mem
        vt[2]  = '{6'h04, 6'h00, 1'b1, 0,   0,   3,  2, 0, 0, 1, 1, 0, 0, 0, 0,  0,  0, 0}; // beq taken
        vt[3]  = '{6'h04, 6'h00, 1'b0, 0,   0,   3,  2, 0, 0, 1, 0, 0, 0, 0, 0,  0,  0, 0}; // beq not taken
        vt[4]  = '{6'h05, 6'h00, 1'b1, 0,   0,   3,  13,0, 0, 1, 1, 0, 0, 0, 0,  0,  0, 0}; // bne taken
        vt[5]  = '{6'h00, 6'h00, 1'b0, 0,   0,   4,  9, 1, 0, 0, 0, 5, 0, 0, 0,  0,  0, 0}; // sll
        vt[6]  = '{6'h0d, 6'h00, 1'b0, 0,   0,   4,  4, 0, 1, 0, 0, 5, 1, 0, 0,  0,  0, 0}; // ori
        vt[7]  = '{6'h0f, 6'h00, 1'b0, 0,   0,   4,  12,0, 1, 2, 0, 5, 1, 0, 0,  0,  0, 0}; // lui
        vt[8]  = '{6'h2b, 6'h00, 1'b0, 0,   0,   4,  1, 0, 1, 1, 0, 0, 0, 0, 1,  1,  0, 0}; // sw
        vt[9]  = '{6'h03, 6'h00, 1'b0, 0,   0,   3,  0, 0, 0, 0, 2, 3, 2, 2, 0,  0,  0, 0}; // jal
        vt[10] = '{6'h00, 6'h08, 1'b0, 0,   0,   3,  0, 0, 0, 0, 3, 0, 0, 0, 0,  0,  0, 0}; // jr
        vt[11] = '{6'h02, 6'h00, 1'b0, 0,   0,   3,  0, 0, 0, 0, 2, 0, 0, 0, 0,  0,  0, 0}; // j
        vt[12] = '{6'h3f, 6'h00, 1'b0, 0,   0,   3,  0, 0, 0, 0, 4, 0, 0, 0, 0,  0,  1, 1}; // bad opcode
        vt[13] = '{6'h00, 6'h3f, 1'b0, 0,   0,   3,  0, 0, 0, 0, 4, 0, 0, 0, 0,  0,  1, 1}; // bad funct
        vt[14] = '{6'h2b, 6'h00, 1'b0, 0,   100, 20, 1, 0, 1, 1, 4, 0, 0, 0, 16, 16, 1, 2}; // sw mem timeout
        vt[15] = '{6'h00, 6'h21, 1'b0, 100, 0,   17, 0, 0, 0, 0, 4, 0, 0, 0, 0,  0,  1, 2}; // fetch timeout
        vt[16] = '{6'h00, 6'h23, 1'b0, 0,   0,   4,  2, 0, 0, 0, 0, 5, 0, 0, 0,  0,  0, 0}; // subu
        vt[17] = '{6'h09, 6'h00, 1'b0, 1,   0,   5,  1, 0, 1, 1, 0, 5, 1, 0, 0,  0,  0, 0}; // addiu, 1 wait

        rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0; Zero = 1'b0;
        #3;
        check("reset_outputs", int'(all_outs), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_after_release", int'(state), 0);
        @(negedge clk); #1;
        check("fetch_after_release", int'(state), 1);

        for (int i = 0; i < NV; i++) begin
            run_instr(vt[i].op, vt[i].fn, vt[i].z, vt[i].fdly, vt[i].mdly);
            check($sformatf("v%0d_cycles", i),    c_cyc,  vt[i].cyc);
            check($sformatf("v%0d_aluop", i),     c_alu,  vt[i].alu);
            check($sformatf("v%0d_asel", i),      c_asel, vt[i].asel);
            check($sformatf("v%0d_bsel", i),      c_bsel, vt[i].bsel);
            check($sformatf("v%0d_extop", i),     c_ext,  vt[i].ext);
            check($sformatf("v%0d_npcop", i),     c_npc,  vt[i].npc);
            check($sformatf("v%0d_pcwr_count", i), c_pcwr, 1);
            check($sformatf("v%0d_rfwr_state", i), c_rfst, vt[i].rfst);
            check($sformatf("v%0d_gprsel", i),    c_gpr,  vt[i].gpr);
            check($sformatf("v%0d_wdsel", i),     c_wd,   vt[i].wd);
            check($sformatf("v%0d_iord_cycles", i), c_iord, vt[i].iord);
            check($sformatf("v%0d_dmwr_cycles", i), c_dmwr, vt[i].dmwr);
            check($sformatf("v%0d_dmwr_in_exc", i), c_dmwr_exc, 0);
            check($sformatf("v%0d_exc", i),       c_exc,  vt[i].exc);
            check($sformatf("v%0d_done_plus_exc", i), c_done + c_exc, 1);
            if (vt[i].exc != 0)
                check($sformatf("v%0d_exc_cause", i), c_cause, vt[i].cause);
        end

        // Cause from the fetch timeout persists across later clean instructions.
        check("cause_hold_timeout", int'(exc_cause), 2);
        run_instr(6'h3f, 6'h00, 1'b0, 0, 0);
        check("cause_illegal", c_cause, 1);
        run_instr(6'h00, 6'h21, 1'b0, 0, 0);
        check("cause_hold_illegal", int'(exc_cause), 1);

        // Store stalled in MEM, then asynchronous reset mid-request.
        opcode = 6'h2b; funct = 6'h00; mem_ready = 1'b1;
        fin = 1'b0;
        for (int k = 0; k < 8 && !fin; k++) begin
            if (state == 3'd4) fin = 1'b1;
            else begin @(negedge clk); #1; end
        end
        mem_ready = 1'b0;
        check("reach_mem", int'(fin), 1);
        @(negedge clk); #1;
        check("sw_mem_state", int'(state), 4);
        check("sw_dmwr_before_reset", int'(DMWr), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", int'(all_outs), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_after_midop_reset", int'(state), 0);
        @(negedge clk); #1;
        check("fetch_after_midop_reset", int'(state), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
